// File: rtl/set_bit_scanner.sv
// Serialises a multi-hot word into a stream of set-bit indices, one per beat,
// in LSB-first or MSB-first order, tagging each burst with last/empty/popcount.
module set_bit_scanner #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_msb_first,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(WIDTH)-1:0]   out_index,
  output logic                       out_last,
  output logic                       out_empty,
  output logic [$clog2(WIDTH+1)-1:0] out_count
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   residual_q, residual_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [IDX_W-1:0]   lo_idx, hi_idx, cur_idx;
  logic [CNT_W-1:0]   in_popcount;
  logic               scanning, at_most_one, accept, beat_fire;

  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    // Descending loop leaves the lowest set bit, ascending leaves the highest.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (residual_q[i]) lo_idx = IDX_W'(i);
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (residual_q[i]) hi_idx = IDX_W'(i);
    end
  end

  always_comb begin
    in_popcount = '0;
    for (int i = 0; i < WIDTH; i++) begin
      in_popcount = in_popcount + CNT_W'(in_data[i]);
    end
  end

  assign cur_idx     = mode_q ? hi_idx : lo_idx;
  assign scanning    = (state_q == StScan);
  assign at_most_one = ((residual_q & (residual_q - {{(WIDTH-1){1'b0}}, 1'b1})) == '0);

  assign out_valid = scanning;
  assign out_index = scanning ? cur_idx : '0;
  assign out_last  = scanning && at_most_one;
  assign out_empty = scanning && (residual_q == '0);
  assign out_count = scanning ? count_q : '0;

  assign beat_fire = out_valid && out_ready;
  assign in_ready  = !rst && (!scanning || (beat_fire && out_last));
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    residual_d = residual_q;
    mode_d     = mode_q;
    count_d    = count_q;
    if (accept) begin
      state_d    = StScan;
      residual_d = in_data;
      mode_d     = in_msb_first;
      count_d    = in_popcount;
    end else if (beat_fire) begin
      residual_d = residual_q & ~({{(WIDTH-1){1'b0}}, 1'b1} << cur_idx);
      if (out_last) state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      residual_q <= '0;
      mode_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      residual_q <= residual_d;
      mode_q     <= mode_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_set_bit_scanner.sv
// Bench for set_bit_scanner: directed steps plus randomized words on an 8-bit
// instance, and a back-to-back check on a 32-bit instance.
module tb_set_bit_scanner;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid8, in_ready8, in_msb8, out_valid8, out_ready8, out_last8, out_empty8;
  logic [7:0] in_data8;
  logic [2:0] out_index8;
  logic [3:0] out_count8;

  logic        in_valid32, in_ready32, in_msb32, out_valid32, out_ready32, out_last32;
  logic        out_empty32;
  logic [31:0] in_data32;
  logic [4:0]  out_index32;
  logic [5:0]  out_count32;

  set_bit_scanner #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_msb_first(in_msb8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_index(out_index8),
    .out_last(out_last8), .out_empty(out_empty8), .out_count(out_count8)
  );

  set_bit_scanner #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid32), .in_ready(in_ready32), .in_data(in_data32), .in_msb_first(in_msb32),
    .out_valid(out_valid32), .out_ready(out_ready32), .out_index(out_index32),
    .out_last(out_last32), .out_empty(out_empty32), .out_count(out_count32)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: list the set-bit positions of the word in the requested order.
  task automatic model_beats(input logic [7:0] w, input logic msb, output int q[$]);
    q = {};
    for (int i = 0; i < 8; i++) begin
      if (((w >> i) & 8'd1) != 0) begin
        if (msb) q.push_front(i);
        else     q.push_back(i);
      end
    end
    if (q.size() == 0) q.push_back(0);
  endtask

  task automatic send8(input logic [7:0] w, input logic msb, input bit rand_ready,
                       input string tag);
    int exp_q[$];
    int n;
    int pc;
    int nbeats;
    model_beats(w, msb, exp_q);
    nbeats = exp_q.size();
    pc = $countones(w);
    in_valid8 = 1'b1; in_data8 = w; in_msb8 = msb; out_ready8 = 1'b0;
    #1;
    chk({tag, "_in_ready"}, in_ready8, 1);
    tick();
    in_valid8 = 1'b0; in_data8 = 8'($urandom); in_msb8 = 1'($urandom);
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      out_ready8 = rand_ready ? (($urandom % 4) != 0) : 1'b1;
      #1;
      chk({tag, "_valid"}, out_valid8, 1);
      chk({tag, "_index"}, out_index8, exp_q[0]);
      chk({tag, "_last"},  out_last8, exp_q.size() == 1);
      chk({tag, "_empty"}, out_empty8, w == 0);
      chk({tag, "_count"}, out_count8, pc);
      if (out_ready8) void'(exp_q.pop_front());
      tick();
      n++;
    end
    chk({tag, "_no_timeout"}, n < 200, 1);
    if (!rand_ready) chk({tag, "_cycles"}, n, nbeats);
    out_ready8 = 1'b0;
    #1;
    chk({tag, "_idle_valid"}, out_valid8, 0);
    chk({tag, "_idle_outs"}, {out_index8, out_last8, out_empty8, out_count8}, 0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid8 = 0; in_data8 = 0; in_msb8 = 0; out_ready8 = 0;
    in_valid32 = 0; in_data32 = 0; in_msb32 = 0; out_ready32 = 0;
    tick();
    tick();
    chk("reset_in_ready", in_ready8, 0);
    chk("reset_outs", {out_valid8, out_index8, out_last8, out_empty8, out_count8}, 0);
    rst = 1'b0;
    #1;
    chk("post_reset_in_ready", in_ready8, 1);

    // Reset in the middle of an 8'hFF burst.
    in_valid8 = 1'b1; in_data8 = 8'hFF; in_msb8 = 1'b0;
    tick();
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    tick();
    tick();
    chk("mid_burst_index", out_index8, 2);
    rst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready8, 0);
    tick();
    chk("rst_out_valid", out_valid8, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_release_in_ready", in_ready8, 1);
    for (int i = 0; i < 4; i++) begin
      chk("rst_no_residual", out_valid8, 0);
      tick();
    end
    out_ready8 = 1'b0;

    send8(8'b1010_0100, 1'b0, 1'b0, "lsb");
    send8(8'b1010_0100, 1'b1, 1'b0, "msb");
    send8(8'h00,        1'b0, 1'b0, "empty");
    send8(8'h80,        1'b1, 1'b0, "top_bit");

    // Backpressure on 8'h81.
    in_valid8 = 1'b1; in_data8 = 8'h81; in_msb8 = 1'b0; out_ready8 = 1'b0;
    tick();
    in_valid8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", out_valid8, 1);
      chk("bp_index", out_index8, 0);
      chk("bp_last", out_last8, 0);
      tick();
    end
    out_ready8 = 1'b1;
    #1;
    chk("bp_release_index", out_index8, 0);
    tick();
    chk("bp_second_index", out_index8, 7);
    chk("bp_second_last", out_last8, 1);
    tick();
    chk("bp_done", out_valid8, 0);
    out_ready8 = 1'b0;

    // Back-to-back on the 32-bit instance.
    in_valid32 = 1'b1; in_data32 = 32'h8000_0001; in_msb32 = 1'b0;
    tick();
    in_valid32 = 1'b0; out_ready32 = 1'b1;
    #1;
    chk("b2b_beat0_index", out_index32, 0);
    chk("b2b_beat0_last", out_last32, 0);
    chk("b2b_beat0_count", out_count32, 2);
    tick();
    in_valid32 = 1'b1; in_data32 = 32'h0000_0010; in_msb32 = 1'b0;
    #1;
    chk("b2b_beat1_index", out_index32, 31);
    chk("b2b_beat1_last", out_last32, 1);
    chk("b2b_accept_on_last", in_ready32, 1);
    tick();
    in_valid32 = 1'b0;
    #1;
    chk("b2b_beat2_valid", out_valid32, 1);
    chk("b2b_beat2_index", out_index32, 4);
    chk("b2b_beat2_last", out_last32, 1);
    chk("b2b_beat2_count", out_count32, 1);
    tick();
    chk("b2b_idle", out_valid32, 0);
    out_ready32 = 1'b0;

    // Randomized words with random backpressure.
    for (int k = 0; k < 40; k++) begin
      logic [7:0] w;
      w = ($urandom % 8 == 0) ? 8'h00 : 8'($urandom);
      send8(w, 1'($urandom), 1'b1, "rand");
      for (int g = 0; g < int'($urandom % 3); g++) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/set_bit_scanner.md
Name: set_bit_scanner

Overview:
- Parametrised successor to the team's combinational set-bit-to-index encoder.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits the index of every set bit, one index per beat, on a valid/ready output stream.
- Scan order (LSB-first or MSB-first) is selectable per word; each burst carries a last flag, an empty flag and the word's popcount.
- Used wherever a multi-hot request/status vector must be serialised into indices.

Parameters:
- WIDTH, 8, input word width; legal range 2..64.
- IDX_W, $clog2(WIDTH), derived localparam; width of out_index.
- CNT_W, $clog2(WIDTH+1), derived localparam; width of out_count.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input word offered.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  WIDTH  word to scan.
- in_msb_first  in  1  scan order; 1 = highest index first. Sampled with in_data.
- out_valid  out  1  out_index is valid.
- out_ready  in  1  downstream accepts the current beat.
- out_index  out  IDX_W  index of the current set bit.
- out_last  out  1  final beat of the current word.
- out_empty  out  1  word had no set bits; the beat carries no index.
- out_count  out  CNT_W  popcount of the current word; constant for the whole burst.

Behaviour:
- Reset
  - While rst=1 at a clock edge: state <= IDLE; residual, mode and count registers <= 0.
  - in_ready=0 while rst=1.
  - out_valid, out_index, out_last, out_empty and out_count all read 0 from the cycle after reset is sampled.
  - Reset mid-burst abandons the burst silently; no further beats for that word.
- States: IDLE and SCAN.
- IDLE
  - in_ready=1 and out_valid=0.
  - Accept on in_valid&&in_ready: residual <= in_data, mode <= in_msb_first, count <= popcount(in_data), then go to SCAN.
- SCAN
  - out_valid=1.
  - out_index is combinational from the registered residual: lowest set bit if mode=0, highest set bit if mode=1.
  - out_last=1 when residual has at most one set bit.
  - out_empty=1 only when residual==0, which occurs only for an all-zero word. In that case the burst is a single beat with out_index=0, out_last=1, out_count=0.
- Beat transfer on out_valid&&out_ready: clear the emitted bit in residual.
  - If out_last=1, the burst ends: go to IDLE, or reload if a new word is accepted in the same cycle.
- Back-to-back
  - in_ready is also 1 in SCAN during the cycle where out_valid&&out_ready&&out_last.
  - A word accepted then is loaded directly, and its first beat appears on the next cycle with no bubble.
- Latency and throughput
  - First beat of a word appears 1 cycle after acceptance.
  - Sustained rate is one index per cycle with out_ready held at 1.
- Backpressure: while out_valid=1 and out_ready=0, all outputs hold stable.
- Input stalls: in_valid may drop between words without effect. in_data and in_msb_first are ignored when no word is accepted.
- Output masking: all out_* read 0 when out_valid=0.
- Indices are unsigned. Bit WIDTH-1 maps to index WIDTH-1, and no wrap-around occurs.

Test Plan:
- Reset: assert rst for 2 cycles mid-burst of word 8'hFF.
  - Required: out_valid=0 on the cycle after rst is sampled.
  - Required: in_ready=1 on the first cycle after rst deasserts.
  - Required: no residual beats afterwards.
- LSB-first: WIDTH=8, in_data=8'b1010_0100, in_msb_first=0, out_ready=1.
  - Required: beats 2, 5, 7 on consecutive cycles.
  - Required: out_last only on 7; out_count=3 on all beats.
- MSB-first: same word with in_msb_first=1.
  - Required: beats 7, 5, 2, with out_last on 2.
- Empty word: in_data=0.
  - Required: exactly one beat with out_empty=1, out_last=1, out_index=0, out_count=0; then IDLE.
- Backpressure: in_data=8'h81, LSB-first, out_ready=0 for 3 cycles after the first beat.
  - Required: out_index=0 and out_valid=1 hold for all 3 cycles.
  - Required: index 7 follows only after out_ready rises.
- Back-to-back with WIDTH=32: word 32'h8000_0001 then word 32'h0000_0010, both LSB-first.
  - The second word is offered during the last beat of the first.
  - Required: beats 0, 31, 4 on three consecutive cycles.
  - Required: the second word is accepted on the 31 beat with no idle cycle.
